// File: rtl/dram_l2_req_sched_if.sv
// Request, write-data, backend and return signals between sctag/scbuf, the
// scheduler and the DRAM controller backend.
interface dram_l2_req_sched_if;
  logic        sctag_dram_rd_req;
  logic        sctag_dram_rd_dummy_req;
  logic [2:0]  sctag_dram_rd_req_id;
  logic [39:5] sctag_dram_addr;
  logic        sctag_dram_wr_req;
  logic        scbuf_dram_data_vld_r5;
  logic        scbuf_dram_data_mecc_r5;
  logic        dram_sctag_rd_ack;
  logic        dram_sctag_wr_ack;
  logic        mc_rd_vld;
  logic [39:5] mc_rd_addr;
  logic [2:0]  mc_rd_id;
  logic        mc_rd_gnt;
  logic        mc_wr_vld;
  logic [39:5] mc_wr_addr;
  logic        mc_wr_mecc;
  logic        mc_wr_gnt;
  logic        mc_rtn_vld;
  logic [2:0]  mc_rtn_id;
  logic        dram_sctag_data_vld_r0;
  logic [1:0]  dram_sctag_chunk_id_r0;
  logic [2:0]  dram_sctag_rd_req_id_r0;
  logic        rtn_err;

  // Environment side: sctag/scbuf requesters plus the backend controller.
  modport master (
    output sctag_dram_rd_req, sctag_dram_rd_dummy_req, sctag_dram_rd_req_id,
           sctag_dram_addr, sctag_dram_wr_req, scbuf_dram_data_vld_r5,
           scbuf_dram_data_mecc_r5, mc_rd_gnt, mc_wr_gnt, mc_rtn_vld, mc_rtn_id,
    input  dram_sctag_rd_ack, dram_sctag_wr_ack, mc_rd_vld, mc_rd_addr, mc_rd_id,
           mc_wr_vld, mc_wr_addr, mc_wr_mecc, dram_sctag_data_vld_r0,
           dram_sctag_chunk_id_r0, dram_sctag_rd_req_id_r0, rtn_err
  );

  modport slave (
    input  sctag_dram_rd_req, sctag_dram_rd_dummy_req, sctag_dram_rd_req_id,
           sctag_dram_addr, sctag_dram_wr_req, scbuf_dram_data_vld_r5,
           scbuf_dram_data_mecc_r5, mc_rd_gnt, mc_wr_gnt, mc_rtn_vld, mc_rtn_id,
    output dram_sctag_rd_ack, dram_sctag_wr_ack, mc_rd_vld, mc_rd_addr, mc_rd_id,
           mc_wr_vld, mc_wr_addr, mc_wr_mecc, dram_sctag_data_vld_r0,
           dram_sctag_chunk_id_r0, dram_sctag_rd_req_id_r0, rtn_err
  );
endinterface

// File: rtl/dram_l2_req_sched.sv
// DRAM-side L2 request scheduler: read/write arbitration with one-cycle acks,
// read queue to the backend, write-line slot and read-return chunk sequencer.
module dram_l2_req_sched #(
  parameter int RDQ_DEPTH = 4,
  parameter int WR_BEATS  = 8,
  parameter int RD_CHUNKS = 4
) (
  input logic rclk,
  input logic reset,
  dram_l2_req_sched_if.slave bus
);
  localparam int PW = $clog2(RDQ_DEPTH);
  localparam int CW = $clog2(RDQ_DEPTH + 1);
  localparam int BW = (WR_BEATS > 1) ? $clog2(WR_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT  = BW'(WR_BEATS - 1);
  localparam logic [1:0]    LAST_CHUNK = 2'(RD_CHUNKS - 1);

  typedef struct packed {
    logic [2:0]  id;
    logic [39:5] addr;
  } rdq_entry_t;

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_READY} wr_state_t;

  logic rd_ack_reg, wr_ack_reg, prefer_rd_reg;
  logic rd_elig, wr_elig, rd_grant, wr_grant;
  logic q_full, q_push, q_pop;

  rdq_entry_t        qmem_reg [RDQ_DEPTH];
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]     count_reg, cnt_after_pop;
  logic              head_vld_reg, head_vld_next;
  rdq_entry_t        head_reg, head_next, push_entry;

  wr_state_t         wr_state_reg, wr_state_next;
  logic [BW-1:0]     beat_reg, beat_next;
  logic              mecc_reg, mecc_next, wr_vld_reg;
  logic [39:5]       waddr_reg, waddr_next;

  logic              dvld_reg, err_reg;
  logic [1:0]        chunk_reg;
  logic [2:0]        rid_reg;

  // Arbitration; the priority pointer only moves when both sides competed.
  always_comb begin
    q_full   = (count_reg == CW'(RDQ_DEPTH));
    rd_elig  = bus.sctag_dram_rd_req & ~rd_ack_reg & ~q_full;
    wr_elig  = bus.sctag_dram_wr_req & ~wr_ack_reg & (wr_state_reg == WR_IDLE);
    rd_grant = rd_elig & (~wr_elig | prefer_rd_reg);
    wr_grant = wr_elig & ~rd_grant;
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      rd_ack_reg    <= 1'b0;
      wr_ack_reg    <= 1'b0;
      prefer_rd_reg <= 1'b1;
    end else begin
      rd_ack_reg <= rd_grant;
      wr_ack_reg <= wr_grant;
      if (rd_elig & wr_elig) prefer_rd_reg <= wr_grant;
    end
  end

  // The request is still held during its ack cycle, so id/addr are pushed then.
  always_comb begin
    push_entry    = '{id: bus.sctag_dram_rd_req_id, addr: bus.sctag_dram_addr};
    q_push        = rd_ack_reg & ~bus.sctag_dram_rd_dummy_req;
    q_pop         = head_vld_reg & bus.mc_rd_gnt;
    cnt_after_pop = count_reg - CW'(q_pop);
    rd_ptr_next   = rd_ptr_reg + PW'(q_pop);
    head_vld_next = (cnt_after_pop != '0) | q_push;
    head_next     = (cnt_after_pop == '0) ? push_entry : qmem_reg[rd_ptr_next];
  end

  always_ff @(posedge rclk) begin
    if (q_push) qmem_reg[wr_ptr_reg] <= push_entry;
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      head_vld_reg <= 1'b0;
      head_reg     <= '0;
    end else begin
      if (q_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= cnt_after_pop + CW'(q_push);
      head_vld_reg <= head_vld_next;
      head_reg     <= head_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    beat_next     = beat_reg;
    mecc_next     = mecc_reg;
    waddr_next    = waddr_reg;
    case (wr_state_reg)
      WR_IDLE: if (wr_grant) begin
        wr_state_next = WR_DATA;
        beat_next     = '0;
        mecc_next     = 1'b0;
        waddr_next    = bus.sctag_dram_addr;
      end
      WR_DATA: if (bus.scbuf_dram_data_vld_r5) begin
        mecc_next = mecc_reg | bus.scbuf_dram_data_mecc_r5;
        if (beat_reg == LAST_BEAT) wr_state_next = WR_READY;
        else beat_next = beat_reg + BW'(1);
      end
      WR_READY: if (bus.mc_wr_gnt) wr_state_next = WR_IDLE;
      default: wr_state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      wr_state_reg <= WR_IDLE;
      beat_reg     <= '0;
      mecc_reg     <= 1'b0;
      waddr_reg    <= '0;
      wr_vld_reg   <= 1'b0;
    end else begin
      wr_state_reg <= wr_state_next;
      beat_reg     <= beat_next;
      mecc_reg     <= mecc_next;
      waddr_reg    <= waddr_next;
      wr_vld_reg   <= (wr_state_next == WR_READY);
    end
  end

  // A return pulse during any chunk cycle, including the last, is dropped.
  always_ff @(posedge rclk) begin
    if (reset) begin
      dvld_reg  <= 1'b0;
      chunk_reg <= 2'd0;
      rid_reg   <= 3'd0;
      err_reg   <= 1'b0;
    end else if (dvld_reg) begin
      if (bus.mc_rtn_vld) err_reg <= 1'b1;
      if (chunk_reg == LAST_CHUNK) begin
        dvld_reg  <= 1'b0;
        chunk_reg <= 2'd0;
      end else begin
        chunk_reg <= chunk_reg + 2'd1;
      end
    end else if (bus.mc_rtn_vld) begin
      dvld_reg  <= 1'b1;
      chunk_reg <= 2'd0;
      rid_reg   <= bus.mc_rtn_id;
    end
  end

  assign bus.dram_sctag_rd_ack       = rd_ack_reg;
  assign bus.dram_sctag_wr_ack       = wr_ack_reg;
  assign bus.mc_rd_vld               = head_vld_reg;
  assign bus.mc_rd_addr              = head_reg.addr;
  assign bus.mc_rd_id                = head_reg.id;
  assign bus.mc_wr_vld               = wr_vld_reg;
  assign bus.mc_wr_addr              = waddr_reg;
  assign bus.mc_wr_mecc              = mecc_reg;
  assign bus.dram_sctag_data_vld_r0  = dvld_reg;
  assign bus.dram_sctag_chunk_id_r0  = chunk_reg;
  assign bus.dram_sctag_rd_req_id_r0 = rid_reg;
  assign bus.rtn_err                 = err_reg;
endmodule

// File: tb/tb_dram_l2_req_sched.sv
// Directed scenarios plus randomized traffic checked against a queue/cycle-window
// reference model of the scheduler.
module tb_dram_l2_req_sched;
  localparam int RDQ_DEPTH = 4;
  localparam int WR_BEATS  = 8;
  localparam int RD_CHUNKS = 4;

  logic rclk = 1'b0;
  logic reset = 1'b1;
  always #5 rclk = ~rclk;

  dram_l2_req_sched_if b ();

  dram_l2_req_sched #(.RDQ_DEPTH(RDQ_DEPTH), .WR_BEATS(WR_BEATS), .RD_CHUNKS(RD_CHUNKS)) dut (
    .rclk(rclk), .reset(reset), .bus(b)
  );

  typedef struct packed {
    logic [2:0]  id;
    logic [39:5] addr;
  } rq_t;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model state
  bit          m_rd_ack, m_wr_ack, m_next_rd = 1'b1, m_err, m_wmecc;
  rq_t         m_q[$];
  int          m_wphase;  // 0 idle, 1 collecting beats, 2 line ready
  int          m_beats;
  logic [39:5] m_waddr;
  int          rs_start = 0, rs_end = -1;
  logic [2:0]  m_rid;

  task automatic step();
    bit full, rel, wel, rg, wg;
    if (reset) begin
      m_rd_ack = 0; m_wr_ack = 0; m_next_rd = 1; m_err = 0; m_wmecc = 0;
      m_q.delete(); m_wphase = 0; m_beats = 0; m_waddr = '0;
      rs_start = 0; rs_end = -1; m_rid = '0;
    end else begin
      full = (m_q.size() == RDQ_DEPTH);
      rel  = b.sctag_dram_rd_req && !m_rd_ack && !full;
      wel  = b.sctag_dram_wr_req && !m_wr_ack && (m_wphase == 0);
      rg   = rel && (!wel || m_next_rd);
      wg   = wel && !rg;
      if (rel && wel) m_next_rd = wg;
      if (b.mc_rtn_vld) begin
        if (cyc >= rs_start && cyc <= rs_end) m_err = 1;
        else begin rs_start = cyc + 1; rs_end = cyc + RD_CHUNKS; m_rid = b.mc_rtn_id; end
      end
      if (m_wphase == 1 && b.scbuf_dram_data_vld_r5) begin
        m_wmecc |= b.scbuf_dram_data_mecc_r5;
        m_beats++;
        if (m_beats == WR_BEATS) m_wphase = 2;
      end else if (m_wphase == 2 && b.mc_wr_gnt) m_wphase = 0;
      if (wg) begin m_wphase = 1; m_beats = 0; m_wmecc = 0; m_waddr = b.sctag_dram_addr; end
      if (m_q.size() > 0 && b.mc_rd_gnt) void'(m_q.pop_front());
      if (m_rd_ack && !b.sctag_dram_rd_dummy_req)
        m_q.push_back('{id: b.sctag_dram_rd_req_id, addr: b.sctag_dram_addr});
      m_rd_ack = rg;
      m_wr_ack = wg;
    end
    @(posedge rclk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    b.sctag_dram_rd_req = 0; b.sctag_dram_rd_dummy_req = 0; b.sctag_dram_rd_req_id = '0;
    b.sctag_dram_addr = '0; b.sctag_dram_wr_req = 0; b.scbuf_dram_data_vld_r5 = 0;
    b.scbuf_dram_data_mecc_r5 = 0; b.mc_rd_gnt = 0; b.mc_wr_gnt = 0;
    b.mc_rtn_vld = 0; b.mc_rtn_id = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    step();
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (b.dram_sctag_rd_ack !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ack got %b want 0", b.dram_sctag_rd_ack); end
    n_cmp++; if (b.dram_sctag_wr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ack got %b want 0", b.dram_sctag_wr_ack); end
    n_cmp++; if ({b.mc_rd_vld, b.mc_wr_vld, b.mc_wr_mecc} !== 3'b000) begin n_fail++; $display("FAIL reset_mc_flags got %b want 000", {b.mc_rd_vld, b.mc_wr_vld, b.mc_wr_mecc}); end
    n_cmp++; if ({b.mc_rd_addr, b.mc_rd_id, b.mc_wr_addr} !== '0) begin n_fail++; $display("FAIL reset_addr_id got %h want 0", {b.mc_rd_addr, b.mc_rd_id, b.mc_wr_addr}); end
    n_cmp++; if ({b.dram_sctag_data_vld_r0, b.dram_sctag_chunk_id_r0, b.rtn_err} !== 4'b0) begin n_fail++; $display("FAIL reset_rtn got %b want 0000", {b.dram_sctag_data_vld_r0, b.dram_sctag_chunk_id_r0, b.rtn_err}); end
    $display("test_reset: outputs checked after reset");
  endtask

  task automatic test_single_read();
    do_reset();
    b.sctag_dram_rd_req = 1; b.sctag_dram_rd_req_id = 3'd5; b.sctag_dram_addr = 35'h12345678;
    step();
    n_cmp++; if (b.dram_sctag_rd_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack got %b want 1", b.dram_sctag_rd_ack); end
    n_cmp++; if (b.mc_rd_vld !== 1'b0) begin n_fail++; $display("FAIL single_vld_early got %b want 0", b.mc_rd_vld); end
    step();
    b.sctag_dram_rd_req = 0;
    n_cmp++; if ({b.dram_sctag_rd_ack, b.mc_rd_vld} !== 2'b01) begin n_fail++; $display("FAIL single_ack_vld got %b want 01", {b.dram_sctag_rd_ack, b.mc_rd_vld}); end
    n_cmp++; if ({b.mc_rd_id, b.mc_rd_addr} !== {3'd5, 35'h12345678}) begin n_fail++; $display("FAIL single_head got %h want %h", {b.mc_rd_id, b.mc_rd_addr}, {3'd5, 35'h12345678}); end
    b.mc_rd_gnt = 1;
    step();
    b.mc_rd_gnt = 0;
    n_cmp++; if (b.mc_rd_vld !== 1'b0) begin n_fail++; $display("FAIL single_pop got %b want 0", b.mc_rd_vld); end
    b.mc_rtn_vld = 1; b.mc_rtn_id = 3'd5;
    step();
    b.mc_rtn_vld = 0;
    for (int k = 0; k < RD_CHUNKS; k++) begin
      n_cmp++; if ({b.dram_sctag_data_vld_r0, b.dram_sctag_chunk_id_r0, b.dram_sctag_rd_req_id_r0} !== {1'b1, 2'(k), 3'd5}) begin n_fail++; $display("FAIL single_chunk%0d got %b want %b", k, {b.dram_sctag_data_vld_r0, b.dram_sctag_chunk_id_r0, b.dram_sctag_rd_req_id_r0}, {1'b1, 2'(k), 3'd5}); end
      step();
    end
    n_cmp++; if ({b.dram_sctag_data_vld_r0, b.rtn_err} !== 2'b00) begin n_fail++; $display("FAIL single_rtn_end got %b want 00", {b.dram_sctag_data_vld_r0, b.rtn_err}); end
    $display("test_single_read: id 5 read issued and returned");
  endtask

  task automatic test_arbitration();
    do_reset();
    b.sctag_dram_addr = 35'h0ABCDE0; b.sctag_dram_rd_req_id = 3'd1;
    b.sctag_dram_rd_req = 1; b.sctag_dram_wr_req = 1;
    step();
    n_cmp++; if ({b.dram_sctag_rd_ack, b.dram_sctag_wr_ack} !== 2'b10) begin n_fail++; $display("FAIL arb1_read_first got %b want 10", {b.dram_sctag_rd_ack, b.dram_sctag_wr_ack}); end
    step();
    b.sctag_dram_rd_req = 0;
    n_cmp++; if ({b.dram_sctag_rd_ack, b.dram_sctag_wr_ack} !== 2'b01) begin n_fail++; $display("FAIL arb1_write_second got %b want 01", {b.dram_sctag_rd_ack, b.dram_sctag_wr_ack}); end
    step();
    b.sctag_dram_wr_req = 0;
    n_cmp++; if (b.dram_sctag_wr_ack !== 1'b0) begin n_fail++; $display("FAIL arb1_wr_ack_pulse got %b want 0", b.dram_sctag_wr_ack); end
    b.scbuf_dram_data_vld_r5 = 1;
    for (int i = 0; i < WR_BEATS; i++) step();
    b.scbuf_dram_data_vld_r5 = 0;
    b.mc_wr_gnt = 1; b.mc_rd_gnt = 1;
    step();
    b.mc_wr_gnt = 0; b.mc_rd_gnt = 0;
    step();
    b.sctag_dram_rd_req = 1; b.sctag_dram_wr_req = 1;
    step();
    n_cmp++; if ({b.dram_sctag_rd_ack, b.dram_sctag_wr_ack} !== 2'b01) begin n_fail++; $display("FAIL arb2_write_first got %b want 01", {b.dram_sctag_rd_ack, b.dram_sctag_wr_ack}); end
    step();
    b.sctag_dram_wr_req = 0;
    n_cmp++; if ({b.dram_sctag_rd_ack, b.dram_sctag_wr_ack} !== 2'b10) begin n_fail++; $display("FAIL arb2_read_second got %b want 10", {b.dram_sctag_rd_ack, b.dram_sctag_wr_ack}); end
    step();
    b.sctag_dram_rd_req = 0;
    $display("test_arbitration: two contended pairs checked");
  endtask

  task automatic test_queue_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      b.sctag_dram_rd_req = 1; b.sctag_dram_rd_req_id = 3'(i); b.sctag_dram_addr = 35'(32'h100 * (i + 1));
      step();
      n_cmp++; if (b.dram_sctag_rd_ack !== 1'b1) begin n_fail++; $display("FAIL full_ack%0d got %b want 1", i, b.dram_sctag_rd_ack); end
      step();
      b.sctag_dram_rd_req = 0;
    end
    b.sctag_dram_rd_req = 1; b.sctag_dram_rd_req_id = 3'd4; b.sctag_dram_addr = 35'h500;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (b.dram_sctag_rd_ack !== 1'b0) begin n_fail++; $display("FAIL full_withheld%0d got %b want 0", i, b.dram_sctag_rd_ack); end
    end
    n_cmp++; if ({b.mc_rd_vld, b.mc_rd_id} !== 4'b1000) begin n_fail++; $display("FAIL full_head0 got %b want 1000", {b.mc_rd_vld, b.mc_rd_id}); end
    b.mc_rd_gnt = 1;
    step();
    b.mc_rd_gnt = 0;
    n_cmp++; if (b.dram_sctag_rd_ack !== 1'b0) begin n_fail++; $display("FAIL full_pop_cycle_ack got %b want 0", b.dram_sctag_rd_ack); end
    step();
    n_cmp++; if (b.dram_sctag_rd_ack !== 1'b1) begin n_fail++; $display("FAIL full_fifth_ack got %b want 1", b.dram_sctag_rd_ack); end
    step();
    b.sctag_dram_rd_req = 0;
    for (int k = 1; k <= 4; k++) begin
      n_cmp++; if ({b.mc_rd_vld, b.mc_rd_id, b.mc_rd_addr} !== {1'b1, 3'(k), 35'(32'h100 * (k + 1))}) begin n_fail++; $display("FAIL full_order%0d got %h want %h", k, {b.mc_rd_vld, b.mc_rd_id, b.mc_rd_addr}, {1'b1, 3'(k), 35'(32'h100 * (k + 1))}); end
      b.mc_rd_gnt = 1;
      step();
      b.mc_rd_gnt = 0;
    end
    n_cmp++; if (b.mc_rd_vld !== 1'b0) begin n_fail++; $display("FAIL full_drained got %b want 0", b.mc_rd_vld); end
    $display("test_queue_full: fifth read withheld then ordered drain");
  endtask

  task automatic test_write_mecc();
    do_reset();
    b.sctag_dram_wr_req = 1; b.sctag_dram_addr = 35'h3000040;
    step();
    n_cmp++; if (b.dram_sctag_wr_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack got %b want 1", b.dram_sctag_wr_ack); end
    step();
    b.sctag_dram_wr_req = 0;
    for (int i = 0; i < WR_BEATS; i++) begin
      n_cmp++; if (b.mc_wr_vld !== 1'b0) begin n_fail++; $display("FAIL wr_vld_early%0d got %b want 0", i, b.mc_wr_vld); end
      b.scbuf_dram_data_vld_r5 = 1; b.scbuf_dram_data_mecc_r5 = (i == 2);
      step();
    end
    n_cmp++; if ({b.mc_wr_vld, b.mc_wr_mecc, b.mc_wr_addr} !== {2'b11, 35'h3000040}) begin n_fail++; $display("FAIL wr_line got %h want %h", {b.mc_wr_vld, b.mc_wr_mecc, b.mc_wr_addr}, {2'b11, 35'h3000040}); end
    b.scbuf_dram_data_mecc_r5 = 0;
    b.sctag_dram_addr = 35'h3000080; b.sctag_dram_wr_req = 1;
    step();
    step();
    b.scbuf_dram_data_vld_r5 = 0;
    n_cmp++; if ({b.dram_sctag_wr_ack, b.mc_wr_vld} !== 2'b01) begin n_fail++; $display("FAIL wr_hold_ready got %b want 01", {b.dram_sctag_wr_ack, b.mc_wr_vld}); end
    b.mc_wr_gnt = 1;
    step();
    b.mc_wr_gnt = 0;
    n_cmp++; if ({b.dram_sctag_wr_ack, b.mc_wr_vld} !== 2'b00) begin n_fail++; $display("FAIL wr_gnt_plus1 got %b want 00", {b.dram_sctag_wr_ack, b.mc_wr_vld}); end
    step();
    n_cmp++; if (b.dram_sctag_wr_ack !== 1'b1) begin n_fail++; $display("FAIL wr_gnt_plus2 got %b want 1", b.dram_sctag_wr_ack); end
    step();
    b.sctag_dram_wr_req = 0;
    b.scbuf_dram_data_vld_r5 = 1;
    for (int i = 0; i < WR_BEATS; i++) step();
    b.scbuf_dram_data_vld_r5 = 0;
    n_cmp++; if ({b.mc_wr_vld, b.mc_wr_mecc, b.mc_wr_addr} !== {2'b10, 35'h3000080}) begin n_fail++; $display("FAIL wr_line2 got %h want %h", {b.mc_wr_vld, b.mc_wr_mecc, b.mc_wr_addr}, {2'b10, 35'h3000080}); end
    $display("test_write_mecc: mecc line and gnt spacing checked");
  endtask

  task automatic test_dummy();
    do_reset();
    b.sctag_dram_rd_req = 1; b.sctag_dram_rd_req_id = 3'd6; b.sctag_dram_addr = 35'h60;
    step(); step();
    b.sctag_dram_rd_req = 0;
    step();
    b.sctag_dram_rd_req = 1; b.sctag_dram_rd_dummy_req = 1; b.sctag_dram_rd_req_id = 3'd2; b.sctag_dram_addr = 35'h20;
    step();
    n_cmp++; if (b.dram_sctag_rd_ack !== 1'b1) begin n_fail++; $display("FAIL dummy_ack got %b want 1", b.dram_sctag_rd_ack); end
    step();
    b.sctag_dram_rd_req = 0; b.sctag_dram_rd_dummy_req = 0;
    n_cmp++; if ({b.mc_rd_vld, b.mc_rd_id} !== 4'b1110) begin n_fail++; $display("FAIL dummy_head got %b want 1110", {b.mc_rd_vld, b.mc_rd_id}); end
    b.mc_rd_gnt = 1;
    step();
    b.mc_rd_gnt = 0;
    n_cmp++; if (b.mc_rd_vld !== 1'b0) begin n_fail++; $display("FAIL dummy_not_queued got %b want 0", b.mc_rd_vld); end
    $display("test_dummy: dummy read acked and not queued");
  endtask

  task automatic test_rtn_err();
    do_reset();
    b.mc_rtn_vld = 1; b.mc_rtn_id = 3'd1;
    step();
    b.mc_rtn_vld = 0;
    step();
    b.mc_rtn_vld = 1; b.mc_rtn_id = 3'd3;
    step();
    b.mc_rtn_vld = 0;
    n_cmp++; if ({b.dram_sctag_data_vld_r0, b.dram_sctag_chunk_id_r0, b.dram_sctag_rd_req_id_r0, b.rtn_err} !== 7'b1_10_001_1) begin n_fail++; $display("FAIL rtn_chunk2 got %b want 1100011", {b.dram_sctag_data_vld_r0, b.dram_sctag_chunk_id_r0, b.dram_sctag_rd_req_id_r0, b.rtn_err}); end
    step();
    n_cmp++; if ({b.dram_sctag_data_vld_r0, b.dram_sctag_chunk_id_r0, b.dram_sctag_rd_req_id_r0} !== 6'b1_11_001) begin n_fail++; $display("FAIL rtn_chunk3 got %b want 111001", {b.dram_sctag_data_vld_r0, b.dram_sctag_chunk_id_r0, b.dram_sctag_rd_req_id_r0}); end
    step(); step(); step();
    n_cmp++; if ({b.dram_sctag_data_vld_r0, b.rtn_err} !== 2'b01) begin n_fail++; $display("FAIL rtn_dropped got %b want 01", {b.dram_sctag_data_vld_r0, b.rtn_err}); end
    do_reset();
    n_cmp++; if (b.rtn_err !== 1'b0) begin n_fail++; $display("FAIL rtn_err_reset got %b want 0", b.rtn_err); end
    $display("test_rtn_err: overlapping return dropped, error sticky until reset");
  endtask

  task automatic test_random();
    bit rd_drop, wr_drop, e_dv;
    int bad;
    rq_t h;
    do_reset();
    rd_drop = 0; wr_drop = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin do_reset(); rd_drop = 0; wr_drop = 0; end
      step();
      bad = n_fail;
      e_dv = (cyc >= rs_start && cyc <= rs_end);
      n_cmp++; if (b.dram_sctag_rd_ack !== m_rd_ack) begin n_fail++; $display("FAIL rnd_rd_ack cyc %0d got %b want %b", cyc, b.dram_sctag_rd_ack, m_rd_ack); end
      n_cmp++; if (b.dram_sctag_wr_ack !== m_wr_ack) begin n_fail++; $display("FAIL rnd_wr_ack cyc %0d got %b want %b", cyc, b.dram_sctag_wr_ack, m_wr_ack); end
      n_cmp++; if (b.mc_rd_vld !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_rd_vld cyc %0d got %b want %b", cyc, b.mc_rd_vld, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        h = m_q[0];
        n_cmp++; if ({b.mc_rd_id, b.mc_rd_addr} !== h) begin n_fail++; $display("FAIL rnd_rd_head cyc %0d got %h want %h", cyc, {b.mc_rd_id, b.mc_rd_addr}, h); end
      end
      n_cmp++; if ({b.mc_wr_vld, b.mc_wr_mecc, b.mc_wr_addr} !== {m_wphase == 2, m_wmecc, m_waddr}) begin n_fail++; $display("FAIL rnd_wr cyc %0d got %h want %h", cyc, {b.mc_wr_vld, b.mc_wr_mecc, b.mc_wr_addr}, {m_wphase == 2, m_wmecc, m_waddr}); end
      n_cmp++; if ({b.dram_sctag_data_vld_r0, b.rtn_err} !== {e_dv, m_err}) begin n_fail++; $display("FAIL rnd_rtn_vld_err cyc %0d got %b want %b", cyc, {b.dram_sctag_data_vld_r0, b.rtn_err}, {e_dv, m_err}); end
      if (e_dv) begin
        n_cmp++; if ({b.dram_sctag_chunk_id_r0, b.dram_sctag_rd_req_id_r0} !== {2'(cyc - rs_start), m_rid}) begin n_fail++; $display("FAIL rnd_chunk cyc %0d got %b want %b", cyc, {b.dram_sctag_chunk_id_r0, b.dram_sctag_rd_req_id_r0}, {2'(cyc - rs_start), m_rid}); end
      end
      if (i % 500 == 0) $display("test_random: cycle %0d, %0d new failures", i, n_fail - bad);
      if (rd_drop) begin b.sctag_dram_rd_req = 0; rd_drop = 0; end
      else if (b.sctag_dram_rd_req && m_rd_ack) rd_drop = 1;
      if (wr_drop) begin b.sctag_dram_wr_req = 0; wr_drop = 0; end
      else if (b.sctag_dram_wr_req && m_wr_ack) wr_drop = 1;
      if (!b.sctag_dram_rd_req && !b.sctag_dram_wr_req)
        b.sctag_dram_addr = {3'($urandom_range(7)), 32'($urandom())};
      if (!b.sctag_dram_rd_req && $urandom_range(2) == 0) begin
        b.sctag_dram_rd_req = 1; b.sctag_dram_rd_req_id = 3'($urandom_range(7));
        b.sctag_dram_rd_dummy_req = ($urandom_range(5) == 0);
      end
      if (!b.sctag_dram_wr_req && $urandom_range(3) == 0) b.sctag_dram_wr_req = 1;
      b.scbuf_dram_data_vld_r5  = $urandom_range(1);
      b.scbuf_dram_data_mecc_r5 = ($urandom_range(7) == 0);
      b.mc_rd_gnt = ($urandom_range(2) == 0);
      b.mc_wr_gnt = $urandom_range(1);
      b.mc_rtn_vld = (cyc > rs_end) && ($urandom_range(5) == 0);
      b.mc_rtn_id  = 3'($urandom_range(7));
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_arbitration();
    test_queue_full();
    test_write_mecc();
    test_dummy();
    test_rtn_err();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
